// File: rtl/pipe_sample_capture_pkg.sv
// Shared widths, defaults and FSM encodings for the per-group pipeline sample capture block.
package pipe_sample_capture_pkg;

  localparam int DW_DEF   = 192;
  localparam int NEVT_DEF = 8;
  localparam int MAXSAMP  = 16;
  localparam int SIDX_W   = 4;   // sample index within a slot
  localparam int LEN_W    = 5;   // stored sample count, 1..16

  typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;
  typedef enum logic {RD_IDLE,  RD_RUN}  rd_state_t;

  function automatic logic [LEN_W-1:0] decode_nsamp(input logic [3:0] n);
    return (n == 4'd0) ? LEN_W'(MAXSAMP) : {1'b0, n};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pipe_sample_capture_if.sv
// Pipeline-in / event-out bundle; slave is the capture block, master is its environment.
interface pipe_sample_capture_if
  import pipe_sample_capture_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          PIPE_RDY;
  logic [DW-1:0] PIPE_DATA;
  logic          L1A_MATCH;
  logic [3:0]    NSAMP;
  logic          RD_EN;
  logic [DW-1:0] DOUT;
  logic          DOUT_VLD;
  logic          DOUT_LAST;
  logic          EVT_AVAIL;
  logic          FULL;
  logic [4:0]    EVT_CNT;
  logic [7:0]    OVFL_CNT;
  logic [7:0]    MISS_CNT;

  modport master (
    output PIPE_RDY, PIPE_DATA, L1A_MATCH, NSAMP, RD_EN,
    input  DOUT, DOUT_VLD, DOUT_LAST, EVT_AVAIL, FULL, EVT_CNT, OVFL_CNT, MISS_CNT
  );

  modport slave (
    input  PIPE_RDY, PIPE_DATA, L1A_MATCH, NSAMP, RD_EN,
    output DOUT, DOUT_VLD, DOUT_LAST, EVT_AVAIL, FULL, EVT_CNT, OVFL_CNT, MISS_CNT
  );

endinterface

// File: rtl/pipe_sample_capture_sample_ram_sdp.sv
// Simple dual-port sample RAM: synchronous write, registered 1-cycle read with read enable.
module sample_ram_sdp #(
  parameter int DW = 192,
  parameter int AW = 7
) (
  input  logic          RDCLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array itself is never reset so it can map onto block RAM; only the read register clears.
  always_ff @(posedge RDCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_sample_capture.sv
// Captures NSAMP pipeline words per L1A-matched trigger into a ring of event slots and
// drains them to the readout through an RD_EN handshake with 1-cycle latency.
module pipe_sample_capture
  import pipe_sample_capture_pkg::*;
#(
  parameter int NEVT = NEVT_DEF,
  parameter int DW   = DW_DEF
) (
  input logic                  RDCLK,
  input logic                  RST,
  pipe_sample_capture_if.slave bus
);

  localparam int PW = $clog2(NEVT);
  localparam int AW = PW + SIDX_W;

  cap_state_t        cap_state;
  rd_state_t         rd_state;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [SIDX_W-1:0] wr_idx, rd_idx, rd_cur_idx;
  logic [LEN_W-1:0]  cap_len;
  logic [LEN_W-1:0]  slot_len [NEVT];
  logic [4:0]        evt_cnt;
  logic [7:0]        ovfl_cnt, miss_cnt;
  logic              dout_vld, dout_last;
  logic [DW-1:0]     ram_q;

  logic in_capture, full, evt_avail, cap_last, rd_fire, rd_last;

  assign in_capture = (cap_state == CAP_RUN);
  assign full       = ({1'b0, evt_cnt} + {5'd0, in_capture}) == 6'(NEVT);
  assign evt_avail  = (evt_cnt != 5'd0);
  assign cap_last   = in_capture && ({1'b0, wr_idx} == (cap_len - LEN_W'(1)));

  // A fresh event always starts at sample 0; rd_idx is only meaningful mid-event.
  assign rd_cur_idx = (rd_state == RD_RUN) ? rd_idx : '0;
  assign rd_fire    = bus.RD_EN && evt_avail;
  assign rd_last    = rd_fire && ({1'b0, rd_cur_idx} == (slot_len[rd_ptr] - LEN_W'(1)));

  sample_ram_sdp #(.DW(DW), .AW(AW)) u_ram (
    .RDCLK (RDCLK),
    .RST   (RST),
    .we    (in_capture),
    .waddr ({wr_ptr, wr_idx}),
    .wdata (bus.PIPE_DATA),
    .re    (rd_fire),
    .raddr ({rd_ptr, rd_cur_idx}),
    .rdata (ram_q)
  );

  // Capture FSM plus trigger-drop accounting.
  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST) begin
      cap_state <= CAP_IDLE;
      wr_ptr    <= '0;
      wr_idx    <= '0;
      cap_len   <= '0;
      ovfl_cnt  <= '0;
      miss_cnt  <= '0;
      for (int i = 0; i < NEVT; i++) slot_len[i] <= '0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (bus.L1A_MATCH) begin
            if (full) begin
              ovfl_cnt <= sat_inc8(ovfl_cnt);
            end else if (!bus.PIPE_RDY) begin
              miss_cnt <= sat_inc8(miss_cnt);
            end else begin
              cap_state <= CAP_RUN;
              cap_len   <= decode_nsamp(bus.NSAMP);
              wr_idx    <= '0;
            end
          end
        end
        CAP_RUN: begin
          if (bus.L1A_MATCH) miss_cnt <= sat_inc8(miss_cnt);
          wr_idx <= wr_idx + 1'b1;
          if (cap_last) begin
            slot_len[wr_ptr] <= cap_len;
            wr_ptr           <= wr_ptr + 1'b1;
            cap_state        <= CAP_IDLE;
          end
        end
        default: cap_state <= CAP_IDLE;
      endcase
    end
  end

  // Read FSM and the shared occupancy count, which both sides move.
  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST) begin
      rd_state  <= RD_IDLE;
      rd_ptr    <= '0;
      rd_idx    <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      dout_vld  <= rd_fire;
      dout_last <= rd_last;
      if (rd_fire) begin
        if (rd_last) begin
          rd_ptr   <= rd_ptr + 1'b1;
          rd_state <= RD_IDLE;
        end else begin
          rd_idx   <= rd_cur_idx + 1'b1;
          rd_state <= RD_RUN;
        end
      end
      case ({cap_last, rd_last})
        2'b10:   evt_cnt <= evt_cnt + 5'd1;
        2'b01:   evt_cnt <= evt_cnt - 5'd1;
        default: evt_cnt <= evt_cnt;
      endcase
    end
  end

  assign bus.DOUT      = ram_q;
  assign bus.DOUT_VLD  = dout_vld;
  assign bus.DOUT_LAST = dout_last;
  assign bus.EVT_AVAIL = evt_avail;
  assign bus.FULL      = full;
  assign bus.EVT_CNT   = evt_cnt;
  assign bus.OVFL_CNT  = ovfl_cnt;
  assign bus.MISS_CNT  = miss_cnt;

endmodule

// File: tb/tb_pipe_sample_capture.sv
// Directed bench for pipe_sample_capture: table of per-event sample counts plus hand-written
// sequences for full/overflow, busy misses, simultaneous completion, stalls and reset abort.
module tb_pipe_sample_capture;
  import pipe_sample_capture_pkg::*;

  localparam int NEVT = 8;
  localparam int W    = DW_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_sample_capture_if #(.DW(W)) bus ();
  pipe_sample_capture #(.NEVT(NEVT), .DW(W)) dut (.RDCLK(clk), .RST(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q [$];
  int           len_q [$];

  typedef struct { logic [3:0] nsamp; int len; } vec_t;
  vec_t vecs [5];

  // Pipeline word for cycle c: eight distinct 24-bit lanes.
  function automatic logic [W-1:0] mk(input int c);
    logic [W-1:0] w;
    w = '0;
    for (int l = 0; l < W / 24; l++) w[l*24 +: 24] = 24'(c * 8 + l);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.PIPE_DATA = mk(cyc);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " DOUT"},      bus.DOUT,            W'(0));
    check({tag, " DOUT_VLD"},  W'(bus.DOUT_VLD),    W'(0));
    check({tag, " DOUT_LAST"}, W'(bus.DOUT_LAST),   W'(0));
    check({tag, " EVT_AVAIL"}, W'(bus.EVT_AVAIL),   W'(0));
    check({tag, " FULL"},      W'(bus.FULL),        W'(0));
    check({tag, " EVT_CNT"},   W'(bus.EVT_CNT),     W'(0));
    check({tag, " OVFL_CNT"},  W'(bus.OVFL_CNT),    W'(0));
    check({tag, " MISS_CNT"},  W'(bus.MISS_CNT),    W'(0));
  endtask

  task automatic pulse_l1a();
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
  endtask

  // Trigger expected to be accepted: the event is the next len pipeline words.
  task automatic fire(input logic [3:0] ns, input int len);
    int c0;
    c0 = cyc;
    bus.NSAMP = ns;
    pulse_l1a();
    for (int i = 1; i <= len; i++) exp_q.push_back(mk(c0 + i));
    len_q.push_back(len);
  endtask

  task automatic read_event(input string tag);
    int len;
    logic [W-1:0] e;
    len = len_q.pop_front();
    bus.RD_EN = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s vld[%0d]", tag, i),  W'(bus.DOUT_VLD),  W'(1));
      check($sformatf("%s data[%0d]", tag, i), bus.DOUT,          e);
      check($sformatf("%s last[%0d]", tag, i), W'(bus.DOUT_LAST), W'(i == len - 1));
    end
    bus.RD_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, rem, guard;
    logic was;
    logic [W-1:0] e, prev;

    vecs[0] = '{4'd4,  4};
    vecs[1] = '{4'd0,  16};
    vecs[2] = '{4'd1,  1};
    vecs[3] = '{4'd15, 15};
    vecs[4] = '{4'd7,  7};

    rst = 1'b1;
    bus.PIPE_RDY  = 1'b1;
    bus.PIPE_DATA = mk(0);
    bus.L1A_MATCH = 1'b0;
    bus.NSAMP     = 4'd0;
    bus.RD_EN     = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Read request with nothing stored is ignored.
    bus.RD_EN = 1'b1;
    repeat (2) tick();
    check("empty rd vld", W'(bus.DOUT_VLD), W'(0));
    check("empty rd cnt", W'(bus.EVT_CNT),  W'(0));
    bus.RD_EN = 1'b0;
    tick();

    // Table: capture one event of each length, then drain it.
    for (int v = 0; v < 5; v++) begin
      fire(vecs[v].nsamp, vecs[v].len);
      repeat (vecs[v].len - 1) tick();
      check($sformatf("vec%0d cnt early", v), W'(bus.EVT_CNT), W'(0));
      tick();
      check($sformatf("vec%0d cnt", v),   W'(bus.EVT_CNT),   W'(1));
      check($sformatf("vec%0d avail", v), W'(bus.EVT_AVAIL), W'(1));
      read_event($sformatf("vec%0d", v));
      check($sformatf("vec%0d cnt drained", v), W'(bus.EVT_CNT), W'(0));
    end

    // Fill every slot; a ninth trigger overflows even with PIPE_RDY low.
    for (int i = 0; i < NEVT; i++) begin
      fire(4'd2, 2);
      repeat (3) tick();
    end
    check("full flag",   W'(bus.FULL),    W'(1));
    check("full cnt",    W'(bus.EVT_CNT), W'(8));
    bus.PIPE_RDY = 1'b0;
    pulse_l1a();
    bus.PIPE_RDY = 1'b1;
    tick();
    check("ovfl cnt",     W'(bus.OVFL_CNT), W'(1));
    check("ovfl no miss", W'(bus.MISS_CNT), W'(0));
    check("ovfl evt cnt", W'(bus.EVT_CNT),  W'(8));
    for (int i = 0; i < NEVT; i++) read_event($sformatf("drain%0d", i));
    check("drain cnt",  W'(bus.EVT_CNT), W'(0));
    check("drain full", W'(bus.FULL),    W'(0));

    // Trigger while capturing, then trigger with the pipeline stopped.
    fire(4'd8, 8);
    tick();
    pulse_l1a();
    repeat (6) tick();
    check("busy miss",    W'(bus.MISS_CNT), W'(1));
    check("busy evt cnt", W'(bus.EVT_CNT),  W'(1));
    bus.PIPE_RDY = 1'b0;
    pulse_l1a();
    bus.PIPE_RDY = 1'b1;
    check("rdy miss",    W'(bus.MISS_CNT), W'(2));
    check("rdy evt cnt", W'(bus.EVT_CNT),  W'(1));
    check("rdy ovfl",    W'(bus.OVFL_CNT), W'(1));
    read_event("busy");

    // Capture of a 3-word event completes on the edge the 4-word read issues its last word.
    fire(4'd4, 4);
    repeat (4) tick();
    c0 = cyc;
    bus.NSAMP = 4'd3;
    bus.L1A_MATCH = 1'b1;
    bus.RD_EN = 1'b1;
    void'(len_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.L1A_MATCH = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("simul data[%0d]", i), bus.DOUT,          e);
      check($sformatf("simul last[%0d]", i), W'(bus.DOUT_LAST), W'(i == 3));
    end
    bus.RD_EN = 1'b0;
    prev = e;
    check("simul evt cnt", W'(bus.EVT_CNT), W'(1));
    for (int i = 1; i <= 3; i++) exp_q.push_back(mk(c0 + i));

    // Drain the new event with RD_EN toggled at random.
    rem = 3;
    guard = 0;
    while (rem > 0 && guard < 200) begin
      was = 1'($urandom_range(0, 1));
      bus.RD_EN = was;
      tick();
      guard++;
      if (was) begin
        e = exp_q.pop_front();
        check($sformatf("rand data%0d", 3 - rem), bus.DOUT,          e);
        check($sformatf("rand last%0d", 3 - rem), W'(bus.DOUT_LAST), W'(rem == 1));
        prev = e;
        rem--;
      end else begin
        check("stall vld",  W'(bus.DOUT_VLD), W'(0));
        check("stall hold", bus.DOUT,         prev);
      end
    end
    bus.RD_EN = 1'b0;
    check("rand words left", W'(rem), W'(0));
    tick();
    check("rand evt cnt", W'(bus.EVT_CNT), W'(0));

    // Reset in the middle of both a read and a 16-sample capture.
    fire(4'd4, 4);
    repeat (4) tick();
    bus.RD_EN = 1'b1;
    bus.NSAMP = 4'd0;
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
    tick();
    check("pre-rst vld", W'(bus.DOUT_VLD), W'(1));
    rst = 1'b1;
    #1;
    check_zero("mid rst");
    bus.RD_EN = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    len_q.delete();
    tick();
    fire(4'd4, 4);
    repeat (4) tick();
    check("post-rst cnt", W'(bus.EVT_CNT), W'(1));
    read_event("post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
